// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and direction constants for the counter sequencer
//
// Purpose: common types used by counter_sequencer and updown_counter.
// Contents:
//   state_t  - sequencer states IDLE, LOAD, RUN, DONE
//   DIR_UP   - count direction code for increment (0)
//   DIR_DOWN - count direction code for decrement (1)
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - loadable up/down modulo-2^WIDTH counter
//
// Purpose: count datapath for the sequencer.
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      synchronous active-high reset, clears the count
//   en     in  1      step the count by one in direction dir
//   ld     in  1      load ld_val (wins over en)
//   ld_val in  WIDTH  value to load
//   dir    in  1      DIR_UP increments, DIR_DOWN decrements
//   q      out WIDTH  current count
module updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Natural wrap of the WIDTH-bit adder gives the modulo behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= ld_val;
        end else if (en) begin
            if (dir == DIR_DOWN) begin
                q <= q - ONE;
            end else begin
                q <= q + ONE;
            end
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - command-driven multi-pass up/down count sequencer
//
// Purpose: accepts one command (start, end, direction, repeat count), then
// counts from start to end (modulo 2^WIDTH) for reps+1 passes and pulses done.
// Ports:
//   clk       in  1          clock, rising edge
//   rst       in  1          synchronous active-high reset
//   cmd_valid in  1          command offered
//   cmd_ready out 1          high only in IDLE
//   cmd_start in  WIDTH      first value of each pass
//   cmd_end   in  WIDTH      terminal value of each pass
//   cmd_dir   in  1          0 = increment, 1 = decrement
//   cmd_reps  in  REP_WIDTH  number of passes minus one
//   hold      in  1          freezes the sequence while high
//   abort     in  1          cancels the current command (ignored in IDLE)
//   cnt_val   out WIDTH      current count
//   pass_idx  out REP_WIDTH  current pass index
//   tick      out 1          RUN cycle with hold low
//   busy      out 1          any state other than IDLE
//   done      out 1          single-cycle completion pulse
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int REP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_start,
    input  logic [WIDTH-1:0]     cmd_end,
    input  logic                 cmd_dir,
    input  logic [REP_WIDTH-1:0] cmd_reps,
    input  logic                 hold,
    input  logic                 abort,
    output logic [WIDTH-1:0]     cnt_val,
    output logic [REP_WIDTH-1:0] pass_idx,
    output logic                 tick,
    output logic                 busy,
    output logic                 done
);

    localparam logic [REP_WIDTH-1:0] REP_ONE = {{(REP_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [WIDTH-1:0]     start_r;
    logic [WIDTH-1:0]     end_r;
    logic                 dir_r;
    logic [REP_WIDTH-1:0] reps_r;

    logic at_end;
    logic last_pass;
    logic run_step;
    logic cnt_en;
    logic cnt_ld;

    assign at_end    = (cnt_val == end_r);
    assign last_pass = (pass_idx == reps_r);

    // A RUN cycle that is allowed to advance: not frozen and not being cancelled.
    assign run_step  = (state == ST_RUN) && !hold && !abort;

    assign cnt_en = run_step && !at_end;
    // Load start on entry to a command and on each pass rollover; an abort
    // suppresses both so the count keeps its value on cancellation.
    assign cnt_ld = ((state == ST_LOAD) && !abort) ||
                    (run_step && at_end && !last_pass);

    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .ld     (cnt_ld),
        .ld_val (start_r),
        .dir    (dir_r),
        .q      (cnt_val)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            start_r  <= '0;
            end_r    <= '0;
            dir_r    <= DIR_UP;
            reps_r   <= '0;
            pass_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // abort has no meaning here and must not block acceptance.
                    if (cmd_valid) begin
                        start_r <= cmd_start;
                        end_r   <= cmd_end;
                        dir_r   <= cmd_dir;
                        reps_r  <= cmd_reps;
                        state   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        pass_idx <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (!hold && at_end) begin
                        if (last_pass) begin
                            state <= ST_DONE;
                        end else begin
                            pass_idx <= pass_idx + REP_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pure decodes of the state register, so they change only at clock edges;
    // tick additionally follows the live hold input.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign tick      = (state == ST_RUN) && !hold;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - directed self-checking bench for counter_sequencer
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_end;
    logic       cmd_dir;
    logic [3:0] cmd_reps;
    logic       hold;
    logic       abort;
    logic [7:0] cnt_val;
    logic [3:0] pass_idx;
    logic       tick;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    int exp_cnt[$];
    int exp_pass[$];

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH     (8),
        .REP_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_dir   (cmd_dir),
        .cmd_reps  (cmd_reps),
        .hold      (hold),
        .abort     (abort),
        .cnt_val   (cnt_val),
        .pass_idx  (pass_idx),
        .tick      (tick),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Handshake in the current (IDLE) cycle, then check the LOAD cycle and
    // advance to the first RUN cycle.
    task automatic issue(input string name, input logic [7:0] s, input logic [7:0] e,
                         input logic d, input logic [3:0] r, input logic with_abort);
        cmd_start = s;
        cmd_end   = e;
        cmd_dir   = d;
        cmd_reps  = r;
        cmd_valid = 1'b1;
        abort     = with_abort;
        #1;
        check({name, " ready_idle"}, cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        abort     = 1'b0;
        #1;
        check({name, " load_busy"}, busy, 1);
        check({name, " load_ready"}, cmd_ready, 0);
        check({name, " load_tick"}, tick, 0);
        step();
    endtask

    // Walks the expected RUN table (optionally freezing with hold at one entry),
    // then checks the DONE pulse and the return to IDLE.
    task automatic run_seq(input string name, input int hold_idx, input int hold_len,
                           input int final_cnt);
        int ticks = 0;
        for (int i = 0; i < exp_cnt.size(); i++) begin
            if (i == hold_idx) begin
                hold = 1'b1;
                for (int h = 0; h < hold_len; h++) begin
                    #1;
                    check({name, " hold_cnt"}, cnt_val, exp_cnt[i]);
                    check({name, " hold_pass"}, pass_idx, exp_pass[i]);
                    check({name, " hold_tick"}, tick, 0);
                    step();
                end
                hold = 1'b0;
            end
            #1;
            check({name, " cnt"}, cnt_val, exp_cnt[i]);
            check({name, " pass"}, pass_idx, exp_pass[i]);
            check({name, " done_early"}, done, 0);
            if (tick) ticks++;
            step();
        end
        check({name, " ticks"}, ticks, exp_cnt.size());
        check({name, " done_pulse"}, done, 1);
        check({name, " done_busy"}, busy, 1);
        check({name, " done_cnt"}, cnt_val, final_cnt);
        step();
        check({name, " done_clear"}, done, 0);
        check({name, " idle_busy"}, busy, 0);
        check({name, " idle_ready"}, cmd_ready, 1);
        check({name, " idle_cnt"}, cnt_val, final_cnt);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_end   = '0;
        cmd_dir   = 1'b0;
        cmd_reps  = '0;
        hold      = 1'b0;
        abort     = 1'b0;
        step();
        step();
        check("rst cnt", cnt_val, 0);
        check("rst pass", pass_idx, 0);
        check("rst busy", busy, 0);
        check("rst ready", cmd_ready, 1);
        check("rst done", done, 0);
        check("rst tick", tick, 0);
        rst = 1'b0;
        step();

        // Two up passes 3..6.
        issue("up2", 8'd3, 8'd6, 1'b0, 4'd1, 1'b0);
        exp_cnt  = '{3, 4, 5, 6, 3, 4, 5, 6};
        exp_pass = '{0, 0, 0, 0, 1, 1, 1, 1};
        run_seq("up2", -1, 0, 6);

        // Down through zero: 1,0,255,254.
        issue("down", 8'd1, 8'd254, 1'b1, 4'd0, 1'b0);
        exp_cnt  = '{1, 0, 255, 254};
        exp_pass = '{0, 0, 0, 0};
        run_seq("down", -1, 0, 254);

        // Up through 255: 254,255,0,1.
        issue("wrap", 8'd254, 8'd1, 1'b0, 4'd0, 1'b0);
        exp_cnt  = '{254, 255, 0, 1};
        exp_pass = '{0, 0, 0, 0};
        run_seq("wrap", -1, 0, 1);

        // start == end: one RUN cycle per pass.
        issue("same", 8'd9, 8'd9, 1'b0, 4'd2, 1'b0);
        exp_cnt  = '{9, 9, 9};
        exp_pass = '{0, 1, 2};
        run_seq("same", -1, 0, 9);

        // Hold for five cycles at count 4 of the first pass.
        issue("hold", 8'd3, 8'd6, 1'b0, 4'd1, 1'b0);
        exp_cnt  = '{3, 4, 5, 6, 3, 4, 5, 6};
        exp_pass = '{0, 0, 0, 0, 1, 1, 1, 1};
        run_seq("hold", 1, 5, 6);

        // Abort at count 5, then a new command (with abort also high in IDLE).
        issue("abrt", 8'd3, 8'd6, 1'b0, 4'd0, 1'b0);
        step();
        step();
        check("abrt at5", cnt_val, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        #1;
        check("abrt busy", busy, 0);
        check("abrt ready", cmd_ready, 1);
        check("abrt done", done, 0);
        issue("after", 8'd10, 8'd11, 1'b0, 4'd0, 1'b1);
        exp_cnt  = '{10, 11};
        exp_pass = '{0, 0};
        run_seq("after", -1, 0, 11);

        // Reset mid-RUN with a simultaneous command offer.
        issue("rstm", 8'd3, 8'd6, 1'b0, 4'd0, 1'b0);
        step();
        check("rstm at4", cnt_val, 4);
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_start = 8'd20;
        cmd_end   = 8'd30;
        step();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check("rstm cnt", cnt_val, 0);
        check("rstm pass", pass_idx, 0);
        check("rstm busy", busy, 0);
        check("rstm ready", cmd_ready, 1);
        check("rstm done", done, 0);
        step();
        check("rstm not_captured", busy, 0);
        check("rstm cnt_hold", cnt_val, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
